// File: rtl/icache_pkg.sv
// Shared definitions for the N-way instruction cache: default geometry,
// FSM state encodings and address-field helpers.
// Optional performance counters in the top are enabled by ICACHE_PERF_CNT_EN.
package icache_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int DEF_CACHE_SIZE = 64;
    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_NUM_BLOCKS = 2;

    // Derived geometry of the default configuration
    localparam int LINE_BYTES = DEF_NUM_BLOCKS * WORD_BYTES;
    localparam int NUM_SETS   = DEF_CACHE_SIZE / (DEF_NUM_WAYS * LINE_BYTES);
    localparam int OFFSET_W   = $clog2(DEF_NUM_BLOCKS);
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int TAG_W      = 32 - 2 - OFFSET_W - INDEX_W;

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;

    // Signal width for a field that may be zero bits wide
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Extract addr[lsb +: width], zero-extended; a zero width yields 0
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int lsb, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/icache_nway_plru_plru_tree.sv
// Combinational tree pseudo-LRU for one set: picks the victim way and
// computes the node bits after an access. A node bit of 1 points right.
module plru_tree
    import icache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1,
    parameter int WAY_W    = width_of(NUM_WAYS)
) (
    input  logic [PLRU_W-1:0] bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [PLRU_W-1:0] next_bits,
    output logic [WAY_W-1:0]  victim
);

    if (NUM_WAYS == 1) begin : g_single
        logic unused_way;
        assign unused_way = ^access_way;
        assign next_bits  = bits;
        assign victim     = '0;
    end else begin : g_tree
        localparam int LEVELS = $clog2(NUM_WAYS);

        // Follow the node pointers from the root down to a leaf
        always_comb begin
            int node;
            victim = '0;
            node   = 0;
            for (int lvl = 0; lvl < LEVELS; lvl++) begin
                victim[LEVELS-1-lvl] = bits[node];
                node = 2 * node + 1 + (bits[node] ? 1 : 0);
            end
        end

        // Point every node on the accessed path away from the accessed half
        always_comb begin
            int node;
            next_bits = bits;
            node      = 0;
            for (int lvl = 0; lvl < LEVELS; lvl++) begin
                next_bits[node] = ~access_way[LEVELS-1-lvl];
                node = 2 * node + 1 + (access_way[LEVELS-1-lvl] ? 1 : 0);
            end
        end
    end

endmodule

// File: rtl/icache_nway_plru.sv
// N-way set-associative instruction cache with tree pseudo-LRU replacement,
// word-serial line fill and a single-cycle invalidate-all flush.
// Define ICACHE_PERF_CNT_EN to add debug_miss, perf_hits and perf_misses.
module icache_nway_plru
    import icache_pkg::*;
#(
    parameter int CACHE_SIZE = 64,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_BLOCKS = 2,
    parameter int BLOCK_SIZE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        proc_valid,
    output logic        proc_ready,
    input  logic [31:0] proc_addr,
    output logic [31:0] proc_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic [31:0] mem_req_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic        debug_miss,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int LINE_B   = NUM_BLOCKS * BLOCK_SIZE;
    localparam int SETS     = CACHE_SIZE / (NUM_WAYS * LINE_B);
    localparam int OFF_BITS = $clog2(NUM_BLOCKS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = 32 - 2 - OFF_BITS - IDX_BITS;
    localparam int OFF_W    = width_of(NUM_BLOCKS);
    localparam int IDX_W    = width_of(SETS);
    localparam int WAY_W    = width_of(NUM_WAYS);
    localparam int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(NUM_BLOCKS - 1);

    logic [1:0]          state;
    logic [31:0]         req_addr;
    logic [OFF_W-1:0]    beat;
    logic [WAY_W-1:0]    fill_way;
    logic                flush_pending;

    logic [31:0]         data_mem  [SETS][NUM_WAYS][NUM_BLOCKS];
    logic [TAG_BITS-1:0] tag_mem   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_mem [SETS];
    logic [PLRU_W-1:0]   plru_mem  [SETS];

    logic [31:0]         off_field, idx_field, tag_field, line_base;
    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                hit, any_invalid;
    logic [WAY_W-1:0]    hit_way, inv_way, victim_way, access_way, plru_victim;
    logic [PLRU_W-1:0]   plru_next;
    logic                unused_bits;

    assign off_field = addr_field(req_addr, 2, OFF_BITS);
    assign idx_field = addr_field(req_addr, 2 + OFF_BITS, IDX_BITS);
    assign tag_field = addr_field(req_addr, 2 + OFF_BITS + IDX_BITS, TAG_BITS);
    assign req_off   = off_field[OFF_W-1:0];
    assign req_idx   = idx_field[IDX_W-1:0];
    assign req_tag   = tag_field[TAG_BITS-1:0];
    assign line_base = req_addr & ~32'(LINE_B - 1);
    assign unused_bits = ^{off_field[31:OFF_W], idx_field[31:IDX_W],
                           tag_field[31:TAG_BITS]};

    // Tag compare across the set, plus the lowest-index invalid way
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        any_invalid = 1'b0;
        inv_way     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                any_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
    end

    assign victim_way = any_invalid ? inv_way : plru_victim;
    assign access_way = (state == ST_FILL) ? fill_way : hit_way;

    // One shared tree instance serves whichever set is being accessed
    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .bits       (plru_mem[req_idx]),
        .access_way (access_way),
        .next_bits  (plru_next),
        .victim     (plru_victim)
    );

    // Data and tag storage; not reset because valid_mem gates every use
    always_ff @(posedge clk) begin
        if (!reset && state == ST_FILL && mem_req_valid && mem_req_ready) begin
            data_mem[req_idx][fill_way][beat] <= mem_req_rdata;
            if (beat == LAST_BEAT) begin
                tag_mem[req_idx][fill_way] <= req_tag;
            end
        end
    end

    // Controller: accept, look up, fill, and apply immediate or deferred flush
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            proc_ready    <= 1'b0;
            proc_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            req_addr      <= '0;
            beat          <= '0;
            fill_way      <= '0;
            flush_pending <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else begin
            proc_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush || flush_pending) begin
                        flush_pending <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid_mem[s] <= '0;
                            plru_mem[s]  <= '0;
                        end
                    end
                    if (proc_valid && !proc_ready) begin
                        req_addr <= proc_addr;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    flush_pending <= flush_pending | flush;
                    if (hit) begin
                        proc_ready        <= 1'b1;
                        proc_rdata        <= data_mem[req_idx][hit_way][req_off];
                        plru_mem[req_idx] <= plru_next;
                        state             <= ST_IDLE;
                    end else begin
                        fill_way      <= victim_way;
                        beat          <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= line_base;
                        state         <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    flush_pending <= flush_pending | flush;
                    if (mem_req_valid && mem_req_ready) begin
                        if (beat == LAST_BEAT) begin
                            mem_req_valid               <= 1'b0;
                            valid_mem[req_idx][fill_way] <= 1'b1;
                            plru_mem[req_idx]           <= plru_next;
                            proc_ready                  <= 1'b1;
                            proc_rdata <= (beat == req_off) ? mem_req_rdata
                                        : data_mem[req_idx][fill_way][req_off];
                            state                       <= ST_IDLE;
                        end else begin
                            beat         <= beat + OFF_W'(1);
                            mem_req_addr <= line_base | (32'(beat + OFF_W'(1)) << 2);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit/miss counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            debug_miss  <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            debug_miss <= (state == ST_LOOKUP) && !hit;
            if (state == ST_LOOKUP && hit && perf_hits != '1) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (state == ST_LOOKUP && !hit && perf_misses != '1) begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule
